// File: rtl/uart_pkg.sv
// Shared UART types and constants: frame states, parity modes, data-width limits.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SYNC   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP1  = 3'd5,
      STOP2  = 3'd6
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int DATA_BITS_MIN = 5;
   localparam int DATA_BITS_MAX = 8;

   // Bit counter only has to reach DATA_BITS_MAX-1.
   localparam int CNT_W = 3;

   // Mode 11 is reserved and behaves like "no parity".
   function automatic logic parityEnabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Narrow words are zero-extended, which leaves the XOR reduction unchanged.
   function automatic logic parityBit(input logic [7:0] d, input logic [1:0] mode);
      return (mode == PAR_ODD) ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/baud_tick_detect.sv
// Turns the generator's toggling baud output into a one-clk tick on each rising edge.
// Latency: tick is combinational from baudClk; valid for the single cycle before the edge is registered.
// Backpressure: none; a stalled baudClk simply produces no ticks.
module baud_tick_detect (
   input  logic clk,
   input  logic rst,
   input  logic baudClk,
   output logic tick
);

   logic baudClkQ;

   // Remember the previous baud level so a 0->1 transition can be seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) baudClkQ <= 1'b0;
      else     baudClkQ <= baudClk;
   end

   assign tick = baudClk & ~baudClkQ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, LSB-first data, optional parity, 1/2 stop bits, one-word holding register.
// Latency: first start edge on the first baud tick after a word reaches IDLE; back-to-back frames have zero gap.
// Backpressure: tx_ready drops while the holding register is full; frames pace themselves purely on baud ticks.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [1:0]           par_mode,
   input  logic                 stop2,
   input  logic                 baud_clk,
   output logic                 baud_en,
   output logic                 txd,
   output logic                 busy,
   output logic                 frame_done
);

   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : gBadWidth
      $error("uart_tx_ctrl: DATA_BITS must lie in 5..8");
   end

   tx_state_t            state;
   logic                 tick;
   logic [DATA_BITS-1:0] holdReg;
   logic                 holdFull;
   logic [DATA_BITS-1:0] shiftReg;
   logic [CNT_W-1:0]     bitCnt;
   logic                 parEnQ;
   logic                 parBitQ;
   logic                 stop2Q;
   logic                 txdQ;
   logic                 baudEnQ;
   logic                 frameDoneQ;

   baud_tick_detect uTick (
      .clk     (clk),
      .rst     (rst),
      .baudClk (baud_clk),
      .tick    (tick)
   );

   assign tx_ready   = ~holdFull;
   assign busy       = (state != IDLE);
   assign txd        = txdQ;
   assign baud_en    = baudEnQ;
   assign frame_done = frameDoneQ;

   // Holding register plus frame sequencer; every bit boundary is a baud tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         holdReg    <= '0;
         holdFull   <= 1'b0;
         shiftReg   <= '0;
         bitCnt     <= '0;
         parEnQ     <= 1'b0;
         parBitQ    <= 1'b0;
         stop2Q     <= 1'b0;
         txdQ       <= 1'b1;
         baudEnQ    <= 1'b0;
         frameDoneQ <= 1'b0;
      end else begin
         frameDoneQ <= 1'b0;
         baudEnQ    <= (state != IDLE) | holdFull;

         // Accept never collides with a load: loads only happen while holdFull is set.
         if (tx_valid && !holdFull) begin
            holdReg  <= tx_data;
            holdFull <= 1'b1;
         end

         case (state)
            IDLE: begin
               txdQ <= 1'b1;
               if (holdFull) begin
                  shiftReg <= holdReg;
                  holdFull <= 1'b0;
                  parEnQ   <= parityEnabled(par_mode);
                  parBitQ  <= parityBit(8'(holdReg), par_mode);
                  stop2Q   <= stop2;
                  state    <= SYNC;
               end
            end
            // Generator phase is unknown right after enable, so align the start edge to a tick.
            SYNC: if (tick) begin
               txdQ  <= 1'b0;
               state <= START;
            end
            START: if (tick) begin
               txdQ     <= shiftReg[0];
               shiftReg <= shiftReg >> 1;
               bitCnt   <= '0;
               state    <= DATA;
            end
            DATA: if (tick) begin
               if (bitCnt < CNT_W'(DATA_BITS - 1)) begin
                  txdQ     <= shiftReg[0];
                  shiftReg <= shiftReg >> 1;
                  bitCnt   <= bitCnt + 1'b1;
               end else if (parEnQ) begin
                  txdQ  <= parBitQ;
                  state <= PARITY;
               end else begin
                  txdQ  <= 1'b1;
                  state <= STOP1;
               end
            end
            PARITY: if (tick) begin
               txdQ  <= 1'b1;
               state <= STOP1;
            end
            STOP1, STOP2: if (tick) begin
               if (state == STOP1 && stop2Q) begin
                  state <= STOP2;
               end else begin
                  frameDoneQ <= 1'b1;
                  // A waiting word starts its start bit on this very tick: no idle gap.
                  if (holdFull) begin
                     shiftReg <= holdReg;
                     holdFull <= 1'b0;
                     parEnQ   <= parityEnabled(par_mode);
                     parBitQ  <= parityBit(8'(holdReg), par_mode);
                     stop2Q   <= stop2;
                     txdQ     <= 1'b0;
                     state    <= START;
                  end else begin
                     txdQ  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame bit patterns, parity, stop bits, back-to-back, reset, stall.
// Latency: baud generator model ticks every 8 clk; bits sampled mid-period.
// Backpressure: words pushed through tx_valid/tx_ready with bounded waits.
module tb_uart_tx_ctrl;
   import uart_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [1:0] par_mode;
   logic       stop2;
   logic       baud_clk;
   logic       baud_en;
   logic       txd;
   logic       busy;
   logic       frame_done;

   int  nVec = 0;
   int  nMis = 0;
   int  doneCnt = 0;
   int  enLow = 0;
   bit  stall = 0;
   bit  capActive = 0;
   int  bcnt = 0;

   uart_tx_ctrl #(.DATA_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .par_mode   (par_mode),
      .stop2      (stop2),
      .baud_clk   (baud_clk),
      .baud_en    (baud_en),
      .txd        (txd),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Baud generator model: toggles every 4 clk unless stalled.
   initial begin
      baud_clk = 0;
      forever begin
         @(negedge clk);
         if (!stall) begin
            bcnt++;
            if (bcnt == 4) begin
               bcnt = 0;
               baud_clk = ~baud_clk;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (frame_done === 1'b1) doneCnt++;
      if (capActive && baud_en !== 1'b1) enLow++;
   end

   task automatic sendWord(input logic [7:0] d);
      bit got = 0;
      tx_data  = d;
      tx_valid = 1;
      for (int k = 0; k < 400; k++) begin
         if (tx_ready === 1'b1) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      if (got) @(negedge clk);
      tx_valid = 0;
      nVec++;
      if (!got) begin
         nMis++;
         $display("FAIL accept_%h: tx_ready=%b want 1 within 400 cycles", d, tx_ready);
      end
   endtask

   // Waits for the start edge, then samples n bits at mid-bit.
   task automatic captureFrame(input int n, output logic [31:0] cap);
      bit seen = 0;
      cap = '0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (txd === 1'b0) begin
            seen = 1;
            break;
         end
      end
      nVec++;
      if (!seen) begin
         nMis++;
         $display("FAIL start_edge: txd=%b want 0 within 400 cycles", txd);
      end
      capActive = 1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         cap[i] = txd;
         if (i < n - 1) repeat (8) @(negedge clk);
      end
      capActive = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(negedge clk);
      nVec++; if (txd !== 1'b1)        begin nMis++; $display("FAIL rst_txd: got %b want 1", txd); end
      nVec++; if (tx_ready !== 1'b1)   begin nMis++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
      nVec++; if (baud_en !== 1'b0)    begin nMis++; $display("FAIL rst_baud_en: got %b want 0", baud_en); end
      nVec++; if (busy !== 1'b0)       begin nMis++; $display("FAIL rst_busy: got %b want 0", busy); end
      nVec++; if (frame_done !== 1'b0) begin nMis++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
      rst = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      logic [31:0] cap;
      logic [9:0]  expv;
      int d0;
      expv = 10'b0101001011;     // transmission order, first bit on the left
      par_mode = PAR_NONE;
      stop2 = 0;
      d0 = doneCnt;
      sendWord(8'hA5);
      captureFrame(10, cap);
      for (int i = 0; i < 10; i++) begin
         nVec++;
         if (cap[i] !== expv[9 - i]) begin
            nMis++; $display("FAIL a5_bit%0d: txd=%b want %b", i, cap[i], expv[9 - i]);
         end
      end
      repeat (6) @(negedge clk);
      nVec++; if (busy !== 1'b0) begin nMis++; $display("FAIL a5_busy_end: got %b want 0", busy); end
      repeat (4) @(negedge clk);
      nVec++; if (baud_en !== 1'b0) begin nMis++; $display("FAIL a5_baud_en_end: got %b want 0", baud_en); end
      nVec++; if (doneCnt !== d0 + 1) begin nMis++; $display("FAIL a5_frame_done: pulses=%0d want %0d", doneCnt - d0, 1); end
   endtask

   task automatic test_parity;
      logic [31:0] cap;
      logic [11:0] expEven;
      logic [10:0] expOdd;
      expEven = 12'b011100000111;
      expOdd  = 11'b01110000001;
      par_mode = PAR_EVEN;
      stop2 = 1;
      sendWord(8'h07);
      captureFrame(12, cap);
      for (int i = 0; i < 12; i++) begin
         nVec++;
         if (cap[i] !== expEven[11 - i]) begin
            nMis++; $display("FAIL even_bit%0d: txd=%b want %b", i, cap[i], expEven[11 - i]);
         end
      end
      repeat (20) @(negedge clk);
      // Odd parity, one stop; config flips to even/two-stop mid-frame.
      par_mode = PAR_ODD;
      stop2 = 0;
      fork
         begin
            sendWord(8'h07);
            captureFrame(11, cap);
         end
         begin
            repeat (30) @(negedge clk);
            par_mode = PAR_EVEN;
            stop2 = 1;
         end
      join
      for (int i = 0; i < 11; i++) begin
         nVec++;
         if (cap[i] !== expOdd[10 - i]) begin
            nMis++; $display("FAIL odd_bit%0d: txd=%b want %b", i, cap[i], expOdd[10 - i]);
         end
      end
      repeat (6) @(negedge clk);
      nVec++; if (busy !== 1'b0) begin nMis++; $display("FAIL odd_one_stop: busy=%b want 0", busy); end
      repeat (10) @(negedge clk);
      sendWord(8'h07);
      captureFrame(12, cap);
      for (int i = 0; i < 12; i++) begin
         nVec++;
         if (cap[i] !== expEven[11 - i]) begin
            nMis++; $display("FAIL newmode_bit%0d: txd=%b want %b", i, cap[i], expEven[11 - i]);
         end
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [31:0] cap;
      logic [19:0] expv;
      int d0;
      expv = 20'b0101010101_0010101011;
      par_mode = PAR_NONE;
      stop2 = 0;
      d0 = doneCnt;
      enLow = 0;
      fork
         begin
            sendWord(8'h55);
            sendWord(8'hAA);
         end
         captureFrame(20, cap);
         begin
            for (int k = 0; k < 400; k++) begin
               @(negedge clk);
               if (capActive) break;
            end
            repeat (40) @(negedge clk);
            nVec++; if (tx_ready !== 1'b0) begin nMis++; $display("FAIL b2b_ready_held: got %b want 0", tx_ready); end
            repeat (80) @(negedge clk);
            nVec++; if (tx_ready !== 1'b1) begin nMis++; $display("FAIL b2b_ready_after: got %b want 1", tx_ready); end
         end
      join
      for (int i = 0; i < 20; i++) begin
         nVec++;
         if (cap[i] !== expv[19 - i]) begin
            nMis++; $display("FAIL b2b_bit%0d: txd=%b want %b", i, cap[i], expv[19 - i]);
         end
      end
      nVec++; if (enLow !== 0) begin nMis++; $display("FAIL b2b_baud_en: low cycles=%0d want 0", enLow); end
      repeat (6) @(negedge clk);
      nVec++; if (doneCnt !== d0 + 2) begin nMis++; $display("FAIL b2b_frame_done: pulses=%0d want 2", doneCnt - d0); end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_mid_reset;
      logic [31:0] cap;
      logic [9:0]  expv;
      int d0;
      bit seen;
      expv = 10'b0001111001;
      par_mode = PAR_NONE;
      stop2 = 0;
      d0 = doneCnt;
      seen = 0;
      fork
         begin
            sendWord(8'h3C);
            sendWord(8'h99);
         end
         begin
            for (int k = 0; k < 400; k++) begin
               @(negedge clk);
               if (txd === 1'b0) begin seen = 1; break; end
            end
            repeat (36) @(negedge clk);   // middle of data bit 3
            rst = 1;
            #1;
            nVec++; if (txd !== 1'b1)        begin nMis++; $display("FAIL mrst_txd: got %b want 1", txd); end
            nVec++; if (tx_ready !== 1'b1)   begin nMis++; $display("FAIL mrst_tx_ready: got %b want 1", tx_ready); end
            nVec++; if (baud_en !== 1'b0)    begin nMis++; $display("FAIL mrst_baud_en: got %b want 0", baud_en); end
            nVec++; if (busy !== 1'b0)       begin nMis++; $display("FAIL mrst_busy: got %b want 0", busy); end
            nVec++; if (frame_done !== 1'b0) begin nMis++; $display("FAIL mrst_frame_done: got %b want 0", frame_done); end
         end
      join
      nVec++; if (!seen) begin nMis++; $display("FAIL mrst_start: start edge seen=%b want 1", seen); end
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (30) @(negedge clk);
      nVec++; if (busy !== 1'b0 || txd !== 1'b1) begin nMis++; $display("FAIL mrst_discard: busy=%b txd=%b want 0 1", busy, txd); end
      nVec++; if (doneCnt !== d0) begin nMis++; $display("FAIL mrst_no_done: pulses=%0d want 0", doneCnt - d0); end
      sendWord(8'h3C);
      captureFrame(10, cap);
      for (int i = 0; i < 10; i++) begin
         nVec++;
         if (cap[i] !== expv[9 - i]) begin
            nMis++; $display("FAIL 3c_bit%0d: txd=%b want %b", i, cap[i], expv[9 - i]);
         end
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_stall;
      logic [31:0] cap;
      logic [9:0]  expv;
      int d0;
      bit seen;
      expv = 10'b0101001011;
      par_mode = PAR_NONE;
      stop2 = 0;
      d0 = doneCnt;
      seen = 0;
      cap = '0;
      sendWord(8'hA5);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (txd === 1'b0) begin seen = 1; break; end
      end
      nVec++; if (!seen) begin nMis++; $display("FAIL stall_start: txd=%b want 0", txd); end
      repeat (4) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         cap[i] = txd;
         if (i == 4) begin
            @(posedge clk);
            stall = 1;
            repeat (50) @(posedge clk);
            #1;
            nVec++; if (txd !== cap[4] || busy !== 1'b1) begin nMis++; $display("FAIL stall_hold: txd=%b busy=%b want %b 1", txd, busy, cap[4]); end
            repeat (50) @(posedge clk);
            stall = 0;
            @(negedge clk);
            nVec++; if (txd !== cap[4]) begin nMis++; $display("FAIL stall_resume: txd=%b want %b", txd, cap[4]); end
         end
         if (i < 9) repeat (8) @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
         nVec++;
         if (cap[i] !== expv[9 - i]) begin
            nMis++; $display("FAIL stall_bit%0d: txd=%b want %b", i, cap[i], expv[9 - i]);
         end
      end
      repeat (8) @(negedge clk);
      nVec++; if (doneCnt !== d0 + 1) begin nMis++; $display("FAIL stall_frame_done: pulses=%0d want 1", doneCnt - d0); end
   endtask

   initial begin
      rst = 1;
      tx_data = '0;
      tx_valid = 0;
      par_mode = PAR_NONE;
      stop2 = 0;
      @(negedge clk);
      test_reset;
      test_basic;
      test_parity;
      test_back_to_back;
      test_mid_reset;
      test_stall;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
